// File: rtl/rom_read_arbiter_if.sv
// Bus bundle for rom_read_arbiter: requests, ROM port, response stream.
// slave = arbiter side, master = requesters/ROM/consumer side.
interface rom_read_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] len0;
  logic [ADDR_W-1:0] len1;
  logic              ack0;
  logic              ack1;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              rsp_last;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1,
    input  rom_data, rsp_ready,
    output ack0, ack1, rom_en, rom_addr,
    output rsp_valid, rsp_data, rsp_id, rsp_last
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1,
    output rom_data, rsp_ready,
    input  ack0, ack1, rom_en, rom_addr,
    input  rsp_valid, rsp_data, rsp_id, rsp_last
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Two-requester round-robin burst reader for an async ROM.
// Optional beat_cnt output with ROM_READ_ARBITER_STATS_EN.
module rom_read_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  rom_read_arbiter_if.slave bus,
  output logic              busy
`ifdef ROM_READ_ARBITER_STATS_EN
  ,
  output logic [15:0]       beat_cnt
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]        state;
  logic              ptr;
  logic              owner;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic              ack0_q;
  logic              ack1_q;
  logic              vld_q;
  logic              id_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;

  logic any_req;
  logic grant1;
  logic issue;

  assign any_req = bus.req0 | bus.req1;
  // req1 wins when alone or when the pointer favours it
  assign grant1  = bus.req1 & (~bus.req0 | ptr);
  assign issue   = (state == BURST) & (~vld_q | bus.rsp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (any_req) begin
            state     <= BURST;
            owner     <= grant1;
            ptr       <= ~grant1;
            ack0_q    <= ~grant1;
            ack1_q    <= grant1;
            cur_addr  <= grant1 ? bus.addr1 : bus.addr0;
            remaining <= grant1 ? bus.len1 : bus.len0;
          end
        end
        (state == BURST): begin
          if (issue) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == '0) state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // output register: loads on a beat, otherwise drains on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b0;
    end else if (issue) begin
      vld_q  <= 1'b1;
      data_q <= bus.rom_data;
      id_q   <= owner;
      last_q <= (remaining == '0);
    end else if (vld_q && bus.rsp_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rom_en    = (state == BURST);
  assign bus.rom_addr  = (state == BURST) ? cur_addr : '0;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_last  = last_q;
  assign busy          = (state == BURST);

`ifdef ROM_READ_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (vld_q && bus.rsp_ready
                 && beat_cnt != 16'hFFFF) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: transaction-level grant model,
// queued expected beats, independent negedge monitor.
module tb_rom_read_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef ROM_READ_ARBITER_STATS_EN
  logic [15:0] beat_cnt;
`endif

  always #5 clk = ~clk;

  rom_read_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  rom_read_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
`ifdef ROM_READ_ARBITER_STATS_EN
    ,
    .beat_cnt(beat_cnt)
`endif
  );

  function automatic logic [7:0] rom_val(input logic [3:0] a);
    logic [7:0] w;
    w = {4'h0, a};
    return 8'(w * 8'h11);
  endfunction

  assign bus.rom_data = rom_val(bus.rom_addr);

  typedef struct {
    logic [7:0] d;
    logic       id;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  bit    ack_q[$];

  int n_vec = 0;
  int n_err = 0;
  int beats_seen = 0;
  int hs_cnt = 0;
  bit force_rdy = 1'b1;
  bit mptr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected completion", nm);
  endtask

  task automatic push_burst(input bit id, input logic [3:0] a,
                            input logic [3:0] l);
    logic [3:0] ad;
    beat_t b;
    ad = a;
    ack_q.push_back(id);
    for (int i = 0; i <= int'(l); i++) begin
      b.d = rom_val(ad);
      b.id = id;
      b.last = (i == int'(l));
      exp_q.push_back(b);
      ad = ad + 4'd1;
    end
  endtask

  // consumer back-pressure
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.rsp_ready = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  logic [7:0] pd;
  logic       pid, plast;
  bit         pstall = 1'b0;
  beat_t      got_e;
  bit         got_a;

  always @(negedge clk) begin
    if (rst) begin
      pstall = 1'b0;
    end else begin
      if (pstall) begin
        chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold_data", 32'(bus.rsp_data), 32'(pd));
        chk("hold_id", 32'(bus.rsp_id), 32'(pid));
        chk("hold_last", 32'(bus.rsp_last), 32'(plast));
      end
      if (bus.ack0 || bus.ack1) begin
        if (ack_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: got %b%b expected none",
                   bus.ack1, bus.ack0);
        end else begin
          got_a = ack_q.pop_front();
          chk("ack_id", 32'({bus.ack1, bus.ack0}),
              got_a ? 32'd2 : 32'd1);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        beats_seen++;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none",
                   bus.rsp_data);
        end else begin
          got_e = exp_q.pop_front();
          chk("rsp_data", 32'(bus.rsp_data), 32'(got_e.d));
          chk("rsp_id", 32'(bus.rsp_id), 32'(got_e.id));
          chk("rsp_last", 32'(bus.rsp_last), 32'(got_e.last));
        end
      end
      pstall = bus.rsp_valid && !bus.rsp_ready;
      pd = bus.rsp_data;
      pid = bus.rsp_id;
      plast = bus.rsp_last;
    end
  end

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && ack_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("drain_timeout");
      exp_q.delete();
      ack_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_round(input bit r0, input bit r1,
                           input logic [3:0] a0, input logic [3:0] l0,
                           input logic [3:0] a1, input logic [3:0] l1);
    bit first;
    bit ok;
    if (r0 && r1) begin
      first = mptr;
      push_burst(first, first ? a1 : a0, first ? l1 : l0);
      push_burst(~first, first ? a0 : a1, first ? l0 : l1);
    end else if (r0 || r1) begin
      push_burst(r1, r1 ? a1 : a0, r1 ? l1 : l0);
      mptr = ~r1;
    end
    @(negedge clk);
    bus.addr0 = a0;
    bus.len0 = l0;
    bus.addr1 = a1;
    bus.len1 = l1;
    bus.req0 = r0;
    bus.req1 = r1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
      if (!bus.req0 && !bus.req1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("grant_timeout");
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    wait_drain();
  endtask

  // req0 3/2 with exact cycle-level latency checks
  task automatic lat_round();
    push_burst(1'b0, 4'd3, 4'd2);
    mptr = 1'b1;
    @(negedge clk);
    bus.addr0 = 4'd3;
    bus.len0 = 4'd2;
    bus.req0 = 1'b1;
    @(posedge clk);
    #1;
    chk("lat_ack0_hi", 32'(bus.ack0), 32'd1);
    chk("lat_ack1_lo", 32'(bus.ack1), 32'd0);
    chk("lat_rom_en", 32'(bus.rom_en), 32'd1);
    chk("lat_rom_addr", 32'(bus.rom_addr), 32'd3);
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_valid_lo", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_ack0_lo", 32'(bus.ack0), 32'd0);
    chk("lat_valid_hi", 32'(bus.rsp_valid), 32'd1);
    chk("lat_first_data", 32'(bus.rsp_data), 32'h33);
    chk("lat_rom_addr2", 32'(bus.rom_addr), 32'd4);
    wait_drain();
  endtask

  initial begin
    int b0;
    bit ok;
    logic [3:0] ra;
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.len0 = '0;
    bus.len1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(bus.ack0), 32'd0);
    chk("rst_ack1", 32'(bus.ack1), 32'd0);
    chk("rst_rom_en", 32'(bus.rom_en), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_last", 32'(bus.rsp_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef ROM_READ_ARBITER_STATS_EN
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    force_rdy = 1'b1;
    lat_round();
    run_round(1'b0, 1'b1, 4'd0, 4'd0, 4'd14, 4'd3);
`ifdef ROM_READ_ARBITER_STATS_EN
    chk("stats_7", 32'(beat_cnt), 32'd7);
`endif
    run_round(1'b1, 1'b1, 4'd1, 4'd1, 4'd9, 4'd2);
    run_round(1'b1, 1'b1, 4'd5, 4'd0, 4'd12, 4'd4);

    force_rdy = 1'b0;
    run_round(1'b1, 1'b0, 4'd0, 4'd5, 4'd0, 4'd0);
    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_round(sel[0], sel[1], 4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom));
    end

    // reset in the middle of a 6-beat burst
    force_rdy = 1'b1;
    ra = 4'($urandom);
    push_burst(1'b0, ra, 4'd5);
    b0 = beats_seen;
    @(negedge clk);
    bus.addr0 = ra;
    bus.len0 = 4'd5;
    bus.req0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ack0) bus.req0 = 1'b0;
      #1;
      if (beats_seen >= b0 + 2) begin
        ok = 1'b1;
        break;
      end
    end
    bus.req0 = 1'b0;
    if (!ok) fail_now("midburst_wait");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_rom_en", 32'(bus.rom_en), 32'd0);
    chk("mrst_last", 32'(bus.rsp_last), 32'd0);
`ifdef ROM_READ_ARBITER_STATS_EN
    chk("mrst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
    exp_q.delete();
    ack_q.delete();
    mptr = 1'b0;
    hs_cnt = 0;
    rst = 1'b0;

    run_round(1'b1, 1'b1, 4'd7, 4'd1, 4'd2, 4'd2);
    force_rdy = 1'b0;
    for (int r = 0; r < 10; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_round(sel[0], sel[1], 4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom));
    end
`ifdef ROM_READ_ARBITER_STATS_EN
    chk("stats_final", 32'(beat_cnt), 32'(hs_cnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
